packet_demux_1to2: RTL and testbench

- Clocked 1-to-2 packet splitter: the opposite direction to the NoC 2-to-1 arbiter.
- Accepts 57-bit packets on one valid/ready input and buffers them in a small FIFO.
- Steers each packet to out1 or out2 by a single bit of its destination field.
- Sits at a router output/ejection point where one link fans out to two downstream consumers. Keeps per-port delivery counters for debug.

---
 rtl/packet_demux_1to2.sv | 144 ++++++++++++++
 tb/tb_packet_demux_1to2.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/packet_demux_1to2.sv
// packet_demux_1to2: 1-to-2 packet splitter. A small input FIFO feeds two
// output registers. The port is chosen by one bit of the destination field.
// Each port has a delivery counter for debug.

// Per-port output register and delivery counter.
module packet_demux_port #(
  parameter int W     = 57,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             move,
  input  logic [W-1:0]     mv_data,
  input  logic             ready,
  output logic [W-1:0]     data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt
);
  logic dlv;
  assign dlv = valid & ready;

  // Output register: a new move overwrites it; a delivery with no move empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (move) begin
      data  <= mv_data;
      valid <= 1'b1;
    end else if (dlv) begin
      valid <= 1'b0;
    end
  end

  // Delivery counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (dlv) cnt <= cnt + CNT_W'(1);
  end
endmodule

module packet_demux_1to2 #(
  parameter int WIDTH_packet = 57,
  parameter int DEST_LSB     = 53,
  parameter int DEST_W       = 4,
  parameter int SEL_BIT      = 0,
  parameter int FIFO_DEPTH   = 2,
  parameter int CNT_W        = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH_packet-1:0] in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH_packet-1:0] out1_data,
  output logic                    out1_valid,
  input  logic                    out1_ready,
  output logic [WIDTH_packet-1:0] out2_data,
  output logic                    out2_valid,
  input  logic                    out2_ready,
  output logic [CNT_W-1:0]        cnt1,
  output logic [CNT_W-1:0]        cnt2
);
  localparam int NUM_PORTS = 2;
  localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW        = $clog2(FIFO_DEPTH + 1);
  // Only SEL_BIT of the destination field matters; the modulo keeps it inside the field.
  localparam int SEL_IDX   = DEST_LSB + (SEL_BIT % DEST_W);

  logic [FIFO_DEPTH-1:0][WIDTH_packet-1:0] mem;
  logic [PTR_W-1:0]                        wr_ptr, rd_ptr;
  logic [CW-1:0]                           count, count_next;
  logic                                    push, pop, sel;
  logic [WIDTH_packet-1:0]                 head;

  logic [NUM_PORTS-1:0]                    move, can_take, port_valid, port_ready;
  logic [NUM_PORTS-1:0][WIDTH_packet-1:0]  port_data;
  logic [NUM_PORTS-1:0][CNT_W-1:0]         port_cnt;

  // Full means stalled for the whole cycle, even if the head leaves.
  assign in_ready = (count < CW'(FIFO_DEPTH)) && !rst;
  assign push     = in_valid && in_ready;

  assign head = mem[rd_ptr];
  assign sel  = head[SEL_IDX];

  assign port_ready = {out2_ready, out1_ready};
  assign can_take   = ~port_valid | port_ready;

  // Strict order: only the head may move, so a stalled head blocks both ports.
  assign pop  = (count != '0) && can_take[sel];
  assign move = {pop & sel, pop & ~sel};

  // FIFO storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Occupancy bookkeeping: push and pop together leave count unchanged.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase
  end

  // FIFO pointers and count; power-of-two depth lets pointers wrap on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_next;
    end
  end

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    packet_demux_port #(
      .W     (WIDTH_packet),
      .CNT_W (CNT_W)
    ) u_port (
      .clk     (clk),
      .rst     (rst),
      .move    (move[p]),
      .mv_data (head),
      .ready   (port_ready[p]),
      .data    (port_data[p]),
      .valid   (port_valid[p]),
      .cnt     (port_cnt[p])
    );
  end

  assign out1_data  = port_data[0];
  assign out1_valid = port_valid[0];
  assign cnt1       = port_cnt[0];
  assign out2_data  = port_data[1];
  assign out2_valid = port_valid[1];
  assign cnt2       = port_cnt[1];
endmodule

// File: tb/tb_packet_demux_1to2.sv
// Bench for packet_demux_1to2: directed scenarios plus random traffic.
// The model is one global queue of accepted packets in arrival order.
// The monitor pops this queue each time a port presents a new packet.
module tb_packet_demux_1to2;
  localparam int W  = 57;
  localparam int CW = 4;
  localparam int SB = 53;

  logic          clk, rst, in_valid, in_ready;
  logic          out1_valid, out1_ready, out2_valid, out2_ready;
  logic [W-1:0]  in_data, out1_data, out2_data;
  logic [CW-1:0] cnt1, cnt2;

  int            checks = 0, errors = 0;
  logic [W-1:0]  gq[$];
  logic [CW-1:0] exp_cnt1 = '0, exp_cnt2 = '0;

  logic          m_pv1 = 0, m_pv2 = 0, m_pr1 = 0, m_pr2 = 0, m_prst = 0;
  logic [W-1:0]  m_pd1 = '0, m_pd2 = '0, m_e;

  packet_demux_1to2 #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out1_data(out1_data), .out1_valid(out1_valid), .out1_ready(out1_ready),
    .out2_data(out2_data), .out2_valid(out2_valid), .out2_ready(out2_ready),
    .cnt1(cnt1), .cnt2(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [W-1:0] mkpkt(input logic s);
    logic [W-1:0] p;
    p[31:0]   = $urandom;
    p[W-1:32] = 25'($urandom);
    p[SB]     = s;
    return p;
  endfunction

  // One cycle: drive just after posedge, sample handshake at negedge, record at posedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r1, input logic r2,
                      input logic rs, output logic acc);
    in_valid = v; in_data = d; out1_ready = r1; out2_ready = r2; rst = rs;
    @(negedge clk);
    acc = v && in_ready;
    @(posedge clk);
    if (acc) gq.push_back(d);
    #1;
  endtask

  task automatic idle(input int n, input logic r1, input logic r2);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, r1, r2, 1'b0, a);
  endtask

  task automatic do_reset();
    logic a;
    step(1'b0, '0, 1'b1, 1'b1, 1'b1, a);
  endtask

  task automatic send(input logic [W-1:0] p, input logic r1, input logic r2);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 20 && !a; i++) step(1'b1, p, r1, r2, 1'b0, a);
    if (!a) fail("send_timeout");
  endtask

  // Monitor: routing/order, hold-under-backpressure, counters, in_ready, reset.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        gq.delete();
        exp_cnt1 = '0;
        exp_cnt2 = '0;
      end else begin
        if (m_prst) begin
          chk("post_rst_v1", 64'(out1_valid), 64'd0);
          chk("post_rst_v2", 64'(out2_valid), 64'd0);
          chk("post_rst_d1", 64'(out1_data), 64'd0);
          chk("post_rst_d2", 64'(out2_data), 64'd0);
        end
        chk("cnt1", 64'(cnt1), 64'(exp_cnt1));
        chk("cnt2", 64'(cnt2), 64'(exp_cnt2));
        if (!m_prst && m_pv1 && !m_pr1) begin
          chk("hold_v1", 64'(out1_valid), 64'd1);
          chk("hold_d1", 64'(out1_data), 64'(m_pd1));
        end
        if (!m_prst && m_pv2 && !m_pr2) begin
          chk("hold_v2", 64'(out2_valid), 64'd1);
          chk("hold_d2", 64'(out2_data), 64'(m_pd2));
        end
        if (out1_valid && (!m_pv1 || m_pr1)) begin
          if (gq.size() == 0) fail("out1_unexpected_packet");
          else begin
            m_e = gq.pop_front();
            chk("out1_data_order", 64'(out1_data), 64'(m_e));
            chk("out1_route", 64'(m_e[SB]), 64'd0);
          end
        end
        if (out2_valid && (!m_pv2 || m_pr2)) begin
          if (gq.size() == 0) fail("out2_unexpected_packet");
          else begin
            m_e = gq.pop_front();
            chk("out2_data_order", 64'(out2_data), 64'(m_e));
            chk("out2_route", 64'(m_e[SB]), 64'd1);
          end
        end
        chk("in_ready_occupancy", 64'(in_ready), 64'(gq.size() < 2));
        if (out1_valid && out1_ready) exp_cnt1++;
        if (out2_valid && out2_ready) exp_cnt2++;
      end
      m_pv1 = out1_valid; m_pr1 = out1_ready; m_pd1 = out1_data;
      m_pv2 = out2_valid; m_pr2 = out2_ready; m_pd2 = out2_data;
      m_prst = rst;
    end
  end

  initial begin
    logic         a;
    logic [W-1:0] pk [3];
    int           n;

    in_valid = 0; in_data = '0; out1_ready = 1; out2_ready = 1; rst = 1;
    for (int i = 0; i < 3; i++) do_reset();
    chk("reset_v1", 64'(out1_valid), 64'd0);
    chk("reset_v2", 64'(out2_valid), 64'd0);
    chk("reset_cnt1", 64'(cnt1), 64'd0);

    // Single packet: latency 2, routed to out1.
    pk[0] = mkpkt(1'b0);
    pk[0][SB+3:SB] = 4'b0000;
    step(1'b1, pk[0], 1'b1, 1'b1, 1'b0, a);
    chk("t1_accept", 64'(a), 64'd1);
    chk("t1_not_yet", 64'(out1_valid), 64'd0);
    step(1'b0, '0, 1'b1, 1'b1, 1'b0, a);
    chk("t1_valid", 64'(out1_valid), 64'd1);
    chk("t1_data", 64'(out1_data), 64'(pk[0]));
    chk("t1_v2_idle", 64'(out2_valid), 64'd0);
    idle(2, 1'b1, 1'b1);
    chk("t1_cnt1", 64'(cnt1), 64'd1);

    // Alternating destinations streamed back to back.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, mkpkt(1'(i % 2)), 1'b1, 1'b1, 1'b0, a);
      chk("t2_in_ready", 64'(a), 64'd1);
    end
    idle(4, 1'b1, 1'b1);
    chk("t2_cnt1", 64'(cnt1), 64'd4);
    chk("t2_cnt2", 64'(cnt2), 64'd4);

    // Backpressure on out1 until the FIFO is full, then drain.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      pk[i] = mkpkt(1'b0);
      step(1'b1, pk[i], 1'b0, 1'b1, 1'b0, a);
      chk("t3_accept", 64'(a), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      chk("t3_full", 64'(in_ready), 64'd0);
      chk("t3_hold", 64'(out1_data), 64'(pk[0]));
      idle(1, 1'b0, 1'b1);
    end
    idle(1, 1'b1, 1'b1);
    chk("t3_drain1", 64'(out1_data), 64'(pk[1]));
    idle(1, 1'b1, 1'b1);
    chk("t3_drain2", 64'(out1_data), 64'(pk[2]));
    idle(1, 1'b1, 1'b1);
    chk("t3_empty", 64'(out1_valid), 64'd0);

    // Head-of-line blocking: out2 packet waits behind a stalled out1 packet.
    do_reset();
    pk[0] = mkpkt(1'b0); pk[1] = mkpkt(1'b0); pk[2] = mkpkt(1'b1);
    for (int i = 0; i < 3; i++) send(pk[i], 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_hol_v2", 64'(out2_valid), 64'd0);
      idle(1, 1'b0, 1'b1);
    end
    idle(1, 1'b1, 1'b1);
    chk("t4_out1_b", 64'(out1_data), 64'(pk[1]));
    chk("t4_v2_still", 64'(out2_valid), 64'd0);
    idle(1, 1'b1, 1'b1);
    chk("t4_out2_c", 64'(out2_data), 64'(pk[2]));
    chk("t4_out2_v", 64'(out2_valid), 64'd1);
    idle(3, 1'b1, 1'b1);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 17; i++) send(mkpkt(1'b1), 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);
    chk("t5_cnt2_wrap", 64'(cnt2), 64'd1);

    // Reset with packets in flight discards everything.
    for (int i = 0; i < 3; i++) send(mkpkt(1'b0), 1'b0, 1'b1);
    chk("t6_pre_v1", 64'(out1_valid), 64'd1);
    do_reset();
    chk("t6_v1", 64'(out1_valid), 64'd0);
    chk("t6_cnt1", 64'(cnt1), 64'd0);
    chk("t6_cnt2", 64'(cnt2), 64'd0);
    chk("t6_in_ready_rst", 64'(in_ready), 64'd0);
    idle(5, 1'b1, 1'b1);
    chk("t6_no_stale_v1", 64'(out1_valid), 64'd0);
    chk("t6_no_stale_v2", 64'(out2_valid), 64'd0);

    // Random traffic with random backpressure and occasional reset.
    for (int i = 0; i < 400; i++)
      step(1'($urandom % 2), mkpkt(1'($urandom % 2)), ($urandom % 4) != 0,
           ($urandom % 4) != 0, ($urandom % 97) == 0, a);

    n = 0;
    while (n < 60 && (gq.size() != 0 || out1_valid || out2_valid)) begin
      idle(1, 1'b1, 1'b1);
      n++;
    end
    chk("drain_model_empty", 64'(gq.size()), 64'd0);
    chk("drain_v1", 64'(out1_valid), 64'd0);
    chk("drain_v2", 64'(out2_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
